enc_disp_scan_ctrl: RTL and testbench
=====================================

Name: enc_disp_scan_ctrl

Overview:
- Sequencing controller for the cascaded 16-to-4 priority-encoder / seven-segment path.
- Synchronises 16 active-low request lines and priority-encodes them.
- Debounces the encoded result and commits a stable 4-bit code with a one-cycle new-code strobe.
- Time-multiplexes a two-digit common-anode seven-segment display showing the code as decimal 0-15.

Parameters:
DEBOUNCE_CYCLES, 1000, consecutive identical samples required before commit (min 2)
SCAN_DIV, 5000, SYSCLK cycles per display digit slot (min 2)

Ports:
SYSCLK  in  1  system clock
NSYSRESET  in  1  synchronous active-low reset
EI  in  1  active-low encoder enable; 1 = all requests ignored
DataIn  in  8  active-low requests 15..8 (bit7 = request 15)
DataIn_0  in  8  active-low requests 7..0 (bit7 = request 7)
Code  out  4  committed encoded index
Valid  out  1  committed code is valid (a request was held)
NewCode  out  1  one-cycle pulse on commit of a valid code
DigSel  out  2  active-low digit enables; bit0 = ones digit, bit1 = tens digit
Seg  out  7  active-low segments, order {g,f,e,d,c,b,a}

Behaviour:
- Clock and reset: one clock, SYSCLK. Reset is synchronous, active-low NSYSRESET; all registers update only on the SYSCLK rising edge.
- Reset values: Code=0, Valid=0, NewCode=0, DigSel=2'b10, Seg=7'b0111111 (dash). Sync flops=all 1; debounce counter=0; scan counter=0.
- Reset mid-operation: outputs take reset values at the next edge. Any partial debounce is discarded. No NewCode is emitted.
- Input sync: EI, DataIn, DataIn_0 pass through 2 flop stages. Stage-2 values feed the encoder.
- Encoder (combinational on stage 2):
  - any = (EI==0) and at least one request low.
  - idx = highest-numbered low request, so request 15 has top priority.
  - Candidate = {any, idx}; idx is forced to 0 when any=0.
- Debounce FSM, states IDLE / COUNT / HOLD:
  - Registered cand_prev; counter cnt saturates at DEBOUNCE_CYCLES-1.
  - IDLE: candidate == committed {Valid,Code}. If candidate differs -> COUNT with cnt=0.
  - COUNT: if candidate != cand_prev, cnt=0 and stay in COUNT. Otherwise cnt++.
  - When cnt reaches DEBOUNCE_CYCLES-1 with candidate still equal to cand_prev:
    - If candidate != committed: commit Valid<=any; Code<=idx when any=1, else Code holds its last value; go to HOLD.
    - If candidate == committed: return to IDLE with no commit.
  - HOLD: lasts one cycle, then -> IDLE.
- NewCode: 1 exactly in the cycle after a commit with any=1. Never pulses on release (any=0).
- Direct transition between two valid codes (e.g. 3 -> 10 with no release) commits and pulses.
- Re-pressing the same key after a committed release commits and pulses again.
- Commit latency: a clean input step appears on Code/Valid 2 (sync) + DEBOUNCE_CYCLES + 1 edges after the input changes.
- Display scan:
  - Scan counter counts 0..SCAN_DIV-1 and wraps. On wrap, the active digit toggles.
  - DigSel = 2'b10 while ones digit is active, 2'b01 while tens digit is active. Never 2'b00.
  - Seg is registered and updated together with DigSel.
- Display contents:
  - Valid=1: ones = Code mod 10. Tens = pattern "1" when Code>=10, else blank 7'b1111111.
  - Valid=0: both digits show dash 7'b0111111.
- Digit patterns, active-low gfedcba:
  0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Scan runs independently of debounce. A commit is reflected on the next Seg update.

Test Plan (DEBOUNCE_CYCLES=4, SCAN_DIV=4):
1. Reset: NSYSRESET=0 for 10 cycles with random inputs -> Code=0, Valid=0, NewCode=0, DigSel=2'b10, Seg=7'b0111111 every cycle. Then release.
2. EI=0, DataIn_0=8'hF7 (request 3), DataIn=8'hFF held -> 7 edges later Valid=1, Code=3, NewCode high exactly 1 cycle. Ones slot Seg=0110000; tens slot Seg=1111111; DigSel alternates every 4 cycles.
3. Priority: DataIn=8'hFB (request 10) together with DataIn_0=8'hF7 -> Code=10, one NewCode pulse. Tens Seg=1111001, ones Seg=1000000. Then drop request 10 -> Code=3 with a new pulse.
4. Bounce: DataIn_0=8'hDF (request 5) for 3 cycles, 8'hFF for 2 cycles, repeated 5 times -> Valid stays 0, NewCode never asserts, display stays dashes.
5. Release and enable: with Code=3 committed, set EI=1 and keep requests low -> Valid=0 after 7 edges, Code stays 3, no NewCode, dashes. Restore EI=0 -> Code=3 recommitted with one pulse.
6. Reset mid-debounce (cnt=2) and mid-scan: NSYSRESET=0 for 1 cycle -> all outputs at reset values on the next edge. Debounce restarts from 0; full latency is required before commit.

Source files
------------

// File: rtl/enc_disp_scan_ctrl.sv
// Request-line priority encoder with debounced commit and a two-digit
// common-anode seven-segment scan showing the committed code as 0-15.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | candidate matches the committed code, nothing pending
//   COUNT | candidate differs, counting consecutive identical samples
//   HOLD  | one-cycle settle after a commit before watching again
module enc_disp_scan_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int SCAN_DIV        = 5000
) (
    input  logic       SYSCLK,
    input  logic       NSYSRESET,
    input  logic       EI,
    input  logic [7:0] DataIn,
    input  logic [7:0] DataIn_0,
    output logic [3:0] Code,
    output logic       Valid,
    output logic       NewCode,
    output logic [1:0] DigSel,
    output logic [6:0] Seg
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
    localparam logic [6:0]    DASH     = 7'b0111111;
    localparam logic [6:0]    BLANK    = 7'b1111111;

    typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   scan_cnt;
    logic            tens_q;
    logic            ei_s1, ei_s2;
    logic [15:0]     req_s1, req_s2;
    logic [4:0]      cand, cand_prev, committed;
    logic            any;
    logic [3:0]      idx;
    logic            commit;

    function automatic logic [6:0] digit_pat(input logic [3:0] d);
        case (d)
            4'd0:    digit_pat = 7'b1000000;
            4'd1:    digit_pat = 7'b1111001;
            4'd2:    digit_pat = 7'b0100100;
            4'd3:    digit_pat = 7'b0110000;
            4'd4:    digit_pat = 7'b0011001;
            4'd5:    digit_pat = 7'b0010010;
            4'd6:    digit_pat = 7'b0000010;
            4'd7:    digit_pat = 7'b1111000;
            4'd8:    digit_pat = 7'b0000000;
            4'd9:    digit_pat = 7'b0010000;
            default: digit_pat = BLANK;
        endcase
    endfunction

    function automatic logic [6:0] slot_pat(input logic v, input logic [3:0] c, input logic tens);
        if (!v)
            slot_pat = DASH;
        else if (tens)
            slot_pat = (c >= 4'd10) ? digit_pat(4'd1) : BLANK;
        else
            slot_pat = digit_pat((c >= 4'd10) ? c - 4'd10 : c);
    endfunction

    always_ff @(posedge SYSCLK) begin
        if (!NSYSRESET) begin
            ei_s1  <= 1'b1;
            ei_s2  <= 1'b1;
            req_s1 <= '1;
            req_s2 <= '1;
        end else begin
            ei_s1  <= EI;
            ei_s2  <= ei_s1;
            req_s1 <= {DataIn, DataIn_0};
            req_s2 <= req_s1;
        end
    end

    // Ascending scan so the highest-numbered low request wins.
    always_comb begin
        any = 1'b0;
        idx = 4'd0;
        if (!ei_s2) begin
            for (int i = 0; i < 16; i++) begin
                if (!req_s2[i]) begin
                    any = 1'b1;
                    idx = i[3:0];
                end
            end
        end
    end

    assign cand = {any, idx};
    // A released code compares as {0,0} so a held release does not re-trigger.
    assign committed = Valid ? {1'b1, Code} : 5'd0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cand != committed) begin
                    state_d = COUNT;
                    cnt_d   = '0;
                end
            end
            COUNT: begin
                if (cand != cand_prev) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    if (cand != committed) begin
                        commit  = 1'b1;
                        state_d = HOLD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge SYSCLK) begin
        if (!NSYSRESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cand_prev <= 5'd0;
            Code      <= 4'd0;
            Valid     <= 1'b0;
            NewCode   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cand_prev <= cand;
            NewCode   <= commit & any;
            if (commit) begin
                Valid <= any;
                if (any)
                    Code <= idx;
            end
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (!NSYSRESET) begin
            scan_cnt <= '0;
            tens_q   <= 1'b0;
            Seg      <= DASH;
        end else if (scan_cnt == SCAN_MAX) begin
            scan_cnt <= '0;
            tens_q   <= ~tens_q;
            Seg      <= slot_pat(Valid, Code, ~tens_q);
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    assign DigSel = {~tens_q, tens_q};

endmodule

// File: tb/tb_enc_disp_scan_ctrl.sv
// Randomised and directed bench for enc_disp_scan_ctrl; outputs are compared
// every cycle against a run-length model of the debounce and a tick-count scan model.
module tb_enc_disp_scan_ctrl;

    localparam int D = 4;
    localparam int S = 4;
    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DIG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                        7'b0000000, 7'b0010000};

    logic       SYSCLK = 1'b0;
    logic       NSYSRESET;
    logic       EI;
    logic [7:0] DataIn, DataIn_0;
    logic [3:0] Code;
    logic       Valid, NewCode;
    logic [1:0] DigSel;
    logic [6:0] Seg;

    int checks = 0;
    int failures = 0;

    enc_disp_scan_ctrl #(.DEBOUNCE_CYCLES(D), .SCAN_DIV(S)) dut (
        .SYSCLK(SYSCLK), .NSYSRESET(NSYSRESET), .EI(EI), .DataIn(DataIn), .DataIn_0(DataIn_0),
        .Code(Code), .Valid(Valid), .NewCode(NewCode), .DigSel(DigSel), .Seg(Seg)
    );

    always #5 SYSCLK = ~SYSCLK;

    // ---------------- behavioural model ----------------
    logic        m_s1_ei = 1'b1, m_s2_ei = 1'b1;
    logic [15:0] m_s1 = '1, m_s2 = '1;
    logic [4:0]  m_prev = 5'd0;
    int          m_run = 0;
    logic        m_hold = 1'b0;
    logic        m_valid = 1'b0, m_new = 1'b0, m_tens = 1'b0;
    logic [3:0]  m_code = 4'd0;
    logic [6:0]  m_seg = DASH;
    int          m_tick = 0;

    function automatic logic [4:0] enc(input logic ei, input logic [15:0] r);
        if (ei) return 5'd0;
        for (int i = 15; i >= 0; i--)
            if (!r[i]) return {1'b1, 4'(i)};
        return 5'd0;
    endfunction

    function automatic logic [6:0] disp(input logic v, input logic [3:0] c, input logic tens);
        if (!v) return DASH;
        if (tens) return (c >= 10) ? DIG[1] : BLANK;
        return DIG[int'(c) % 10];
    endfunction

    always @(posedge SYSCLK) begin
        logic [4:0] cand, comm;
        if (!NSYSRESET) begin
            m_s1_ei = 1'b1; m_s2_ei = 1'b1; m_s1 = '1; m_s2 = '1;
            m_prev = 5'd0; m_run = 0; m_hold = 1'b0;
            m_valid = 1'b0; m_code = 4'd0; m_new = 1'b0;
            m_tick = 0; m_tens = 1'b0; m_seg = DASH;
        end else begin
            cand = enc(m_s2_ei, m_s2);
            m_tick++;
            if (m_tick % S == 0) begin
                m_tens = ~m_tens;
                m_seg  = disp(m_valid, m_code, m_tens);
            end
            m_new = 1'b0;
            // The cycle right after a commit never counts toward a new run.
            if (m_hold) begin
                m_hold = 1'b0;
                m_run  = 0;
            end else if (m_run > 0 && cand == m_prev) begin
                m_run++;
            end else begin
                m_run = 1;
            end
            m_prev = cand;
            comm = m_valid ? {1'b1, m_code} : 5'd0;
            if (m_run >= D + 1 && cand != comm) begin
                m_valid = cand[4];
                if (cand[4]) m_code = cand[3:0];
                m_new  = cand[4];
                m_hold = 1'b1;
            end
            m_s2_ei = m_s1_ei; m_s2 = m_s1;
            m_s1_ei = EI;      m_s1 = {DataIn, DataIn_0};
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("code",    16'(Code),    16'(m_code));
        check("valid",   16'(Valid),   16'(m_valid));
        check("newcode", 16'(NewCode), 16'(m_new));
        check("digsel",  16'(DigSel),  16'(m_tens ? 2'b01 : 2'b10));
        check("seg",     16'(Seg),     16'(m_seg));
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge SYSCLK);
            @(negedge SYSCLK);
            compare_all();
        end
    endtask

    task automatic wait_dig(input logic [1:0] target);
        for (int k = 0; k < 12; k++) begin
            if (DigSel == target) break;
            tick(1);
        end
        check("digsel_reached", 16'(DigSel), 16'(target));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_code"},    16'(Code),    16'd0);
        check({tag, "_valid"},   16'(Valid),   16'd0);
        check({tag, "_newcode"}, 16'(NewCode), 16'd0);
        check({tag, "_digsel"},  16'(DigSel),  16'(2'b10));
        check({tag, "_seg"},     16'(Seg),     16'(DASH));
    endtask

    initial begin
        int np, vseen, len, kind;

        // 1: reset with random inputs
        NSYSRESET = 1'b0;
        for (int k = 0; k < 10; k++) begin
            EI = 1'($urandom); DataIn = 8'($urandom); DataIn_0 = 8'($urandom);
            tick(1);
            check_reset_vals("rst");
        end
        NSYSRESET = 1'b1; EI = 1'b0; DataIn = 8'hFF; DataIn_0 = 8'hFF;
        tick(10);

        // 2: request 3
        DataIn_0 = 8'hF7;
        tick(6);
        check("t2_early_valid", 16'(Valid), 16'd0);
        tick(1);
        check("t2_valid", 16'(Valid), 16'd1);
        check("t2_code", 16'(Code), 16'd3);
        check("t2_pulse", 16'(NewCode), 16'd1);
        tick(1);
        check("t2_pulse_end", 16'(NewCode), 16'd0);
        tick(10);
        wait_dig(2'b01);
        check("t2_tens_seg", 16'(Seg), 16'(7'b1111111));
        wait_dig(2'b10);
        check("t2_ones_seg", 16'(Seg), 16'(7'b0110000));

        // 3: priority 10 over 3, then back to 3
        DataIn = 8'hFB;
        tick(7);
        check("t3_code10", 16'(Code), 16'd10);
        check("t3_pulse10", 16'(NewCode), 16'd1);
        tick(10);
        wait_dig(2'b01);
        check("t3_tens_seg", 16'(Seg), 16'(7'b1111001));
        wait_dig(2'b10);
        check("t3_ones_seg", 16'(Seg), 16'(7'b1000000));
        DataIn = 8'hFF;
        tick(7);
        check("t3_code3", 16'(Code), 16'd3);
        check("t3_pulse3", 16'(NewCode), 16'd1);

        // 4: bounce from released state
        DataIn_0 = 8'hFF;
        tick(12);
        check("t4_released", 16'(Valid), 16'd0);
        np = 0; vseen = 0;
        for (int r = 0; r < 5; r++) begin
            DataIn_0 = 8'hDF;
            for (int k = 0; k < 3; k++) begin tick(1); np += NewCode; vseen += Valid; end
            DataIn_0 = 8'hFF;
            for (int k = 0; k < 2; k++) begin tick(1); np += NewCode; vseen += Valid; end
        end
        for (int k = 0; k < 10; k++) begin tick(1); np += NewCode; vseen += Valid; end
        check("t4_no_pulse", 16'(np), 16'd0);
        check("t4_no_valid", 16'(vseen), 16'd0);
        check("t4_dash", 16'(Seg), 16'(DASH));

        // 5: disable while held, then re-enable
        DataIn_0 = 8'hF7;
        tick(12);
        check("t5_pre_code", 16'(Code), 16'd3);
        EI = 1'b1;
        tick(6);
        check("t5_still_valid", 16'(Valid), 16'd1);
        tick(1);
        check("t5_released", 16'(Valid), 16'd0);
        check("t5_code_hold", 16'(Code), 16'd3);
        check("t5_no_pulse", 16'(NewCode), 16'd0);
        tick(10);
        check("t5_dash", 16'(Seg), 16'(DASH));
        EI = 1'b0;
        tick(7);
        check("t5_recommit", 16'(Valid), 16'd1);
        check("t5_recode", 16'(Code), 16'd3);
        check("t5_repulse", 16'(NewCode), 16'd1);

        // 6: reset mid-debounce and mid-scan
        tick(5);
        DataIn = 8'h7F;
        tick(5);
        NSYSRESET = 1'b0;
        tick(1);
        check_reset_vals("t6");
        NSYSRESET = 1'b1;
        tick(6);
        check("t6_early", 16'(Valid), 16'd0);
        tick(1);
        check("t6_valid", 16'(Valid), 16'd1);
        check("t6_code", 16'(Code), 16'd15);
        check("t6_pulse", 16'(NewCode), 16'd1);

        // random phase
        for (int seg_i = 0; seg_i < 120; seg_i++) begin
            len  = int'($urandom_range(1, 8));
            kind = int'($urandom_range(0, 2));
            EI   = ($urandom_range(0, 7) == 0);
            case (kind)
                0: begin DataIn = 8'hFF; DataIn_0 = 8'hFF; end
                1: {DataIn, DataIn_0} = ~(16'd1 << $urandom_range(0, 15));
                default: {DataIn, DataIn_0} = 16'($urandom);
            endcase
            NSYSRESET = ($urandom_range(0, 29) != 0);
            tick(len);
            NSYSRESET = 1'b1;
        end
        tick(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
